// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment pattern reader: codes, patterns, slot states.
// Optional SEG7_READER_DP_EN widens the sampled pattern to include the decimal point.
package seg7_pkg;

`ifdef SEG7_READER_DP_EN
    localparam int PAT_W = 8;
`else
    localparam int PAT_W = 7;
`endif

    localparam logic [4:0] CODE_DASH  = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h11;
    localparam logic [4:0] CODE_ERR   = 5'h1F;

    // Active-low segment patterns: bit0=top ... bit6=middle
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_A     = 7'h08;
    localparam logic [6:0] PAT_B     = 7'h03;
    localparam logic [6:0] PAT_C     = 7'h46;
    localparam logic [6:0] PAT_D     = 7'h21;
    localparam logic [6:0] PAT_E     = 7'h06;
    localparam logic [6:0] PAT_F     = 7'h0E;
    localparam logic [6:0] PAT_DASH  = 7'h3F;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern to character code lookup.
// Unknown patterns map to CODE_ERR with err set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] code,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        case (pattern)
            PAT_0:     code = 5'h00;
            PAT_1:     code = 5'h01;
            PAT_2:     code = 5'h02;
            PAT_3:     code = 5'h03;
            PAT_4:     code = 5'h04;
            PAT_5:     code = 5'h05;
            PAT_6:     code = 5'h06;
            PAT_7:     code = 5'h07;
            PAT_8:     code = 5'h08;
            PAT_9:     code = 5'h09;
            PAT_A:     code = 5'h0A;
            PAT_B:     code = 5'h0B;
            PAT_C:     code = 5'h0C;
            PAT_D:     code = 5'h0D;
            PAT_E:     code = 5'h0E;
            PAT_F:     code = 5'h0F;
            PAT_DASH:  code = CODE_DASH;
            PAT_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_ERR;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_pattern_reader.sv
// Debounced seven-segment reader: stability filter, repeat suppression, 1-entry output slot.
// Define SEG7_READER_DP_EN to sample the decimal point (8-bit patterns, out_dp output).
module seg7_pattern_reader
    import seg7_pkg::*;
#(
    parameter  int STABLE_COUNT = 4,
    localparam int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             sample_en,
    input  logic [PAT_W-1:0] seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_code,
    output logic             out_err,
    output logic [PAT_W-1:0] out_pattern,
`ifdef SEG7_READER_DP_EN
    output logic             out_dp,
`endif
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] last_pat;
    logic [CNT_W-1:0] cnt;
    logic             last_valid;
    slot_state_t      state;

    logic       match, stable_evt, emit, load, drop, pop;
    logic [4:0] dec_code;
    logic       dec_err;

    seg7_pattern_decode u_decode (
        .pattern (seg_in[6:0]),
        .code    (dec_code),
        .err     (dec_err)
    );

    // The event fires only on the transition into CNT_MAX, so a held pattern emits once.
    always_comb begin
        match      = (seg_in == cand);
        stable_evt = sample_en && (match ? (cnt == CNT_MAX - 1'b1) : (CNT_MAX == CNT_W'(1)));
        emit       = stable_evt && !(last_valid && (seg_in == last_pat));
        pop        = (state == FULL) && out_ready;
        load       = emit && ((state == EMPTY) || out_ready);
        drop       = emit && !load;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cand <= {PAT_W{1'b1}};
            cnt  <= '0;
        end else if (sample_en) begin
            if (!match) begin
                cand <= seg_in;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= EMPTY;
            out_code    <= CODE_BLANK;
            out_err     <= 1'b0;
            out_pattern <= {PAT_W{1'b1}};
            last_pat    <= {PAT_W{1'b1}};
            last_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                state       <= FULL;
                out_code    <= dec_code;
                out_err     <= dec_err;
                out_pattern <= seg_in;
                last_pat    <= seg_in;
                last_valid  <= 1'b1;
            end else if (pop) begin
                state <= EMPTY;
            end
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign out_valid = (state == FULL);
`ifdef SEG7_READER_DP_EN
    assign out_dp = ~out_pattern[7];
`endif

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Directed self-checking bench for seg7_pattern_reader with STABLE_COUNT=4.
module tb_seg7_pattern_reader;
    import seg7_pkg::*;

    logic             CLOCK_50 = 1'b0;
    logic             resetn;
    logic             sample_en;
    logic [PAT_W-1:0] seg_in;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_code;
    logic             out_err;
    logic [PAT_W-1:0] out_pattern;
    logic             overrun;
    logic             clr_overrun;
`ifdef SEG7_READER_DP_EN
    logic             out_dp;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int seen;

    seg7_pattern_reader #(.STABLE_COUNT(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_err     (out_err),
        .out_pattern (out_pattern),
`ifdef SEG7_READER_DP_EN
        .out_dp      (out_dp),
`endif
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // n sample strobes of pattern s; counts cycles on which out_valid was high.
    task automatic smp(input logic [6:0] s, input int n);
        sample_en = 1'b1;
        seg_in    = PAT_W'(s) | (PAT_W > 7 ? {PAT_W{1'b1}} & ~PAT_W'(7'h7F) : '0);
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid) seen++;
        end
        sample_en = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; sample_en = 1'b0; seg_in = '1;
        out_ready = 1'b1; clr_overrun = 1'b0; seen = 0;
        #25;
        chk("rst_valid",   32'(out_valid),   0);
        chk("rst_code",    32'(out_code),    32'h11);
        chk("rst_err",     32'(out_err),     0);
        chk("rst_pattern", 32'(out_pattern[6:0]), 32'h7F);
        chk("rst_overrun", 32'(overrun),     0);
        @(negedge CLOCK_50); resetn = 1'b1;

        // Stable 'd': exactly one output one cycle after the 4th sample
        smp(7'h21, 3);
        chk("d_early_valid", 32'(seen), 0);
        smp(7'h21, 1);
        chk("d_valid", 32'(out_valid), 1);
        chk("d_code",  32'(out_code),  32'h0D);
        chk("d_err",   32'(out_err),   0);
        chk("d_pat",   32'(out_pattern[6:0]), 32'h21);
        seen = 0;
        smp(7'h21, 6);
        chk("d_no_repeat", 32'(seen), 0);

        // Glitch restarts the filter
        smp(7'h06, 3); smp(7'h7F, 1); smp(7'h06, 3);
        chk("glitch_early", 32'(seen), 0);
        smp(7'h06, 1);
        chk("glitch_valid", 32'(out_valid), 1);
        chk("glitch_code",  32'(out_code),  32'h0E);
        tick();
        chk("glitch_pop", 32'(out_valid), 0);

        // Backpressure: second stable event dropped, overrun sticky
        out_ready = 1'b0;
        smp(7'h79, 4);
        chk("bp_code1", 32'(out_code), 32'h01);
        smp(7'h3F, 4);
        chk("bp_valid",   32'(out_valid), 1);
        chk("bp_hold",    32'(out_code),  32'h01);
        chk("bp_holdpat", 32'(out_pattern[6:0]), 32'h79);
        chk("bp_overrun", 32'(overrun),   1);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        chk("clr_overrun", 32'(overrun), 0);
        chk("clr_keep",    32'(out_valid), 1);

        // Simultaneous pop and push: no bubble
        smp(7'h40, 3);
        out_ready = 1'b1;
        smp(7'h40, 1);
        chk("pp_valid", 32'(out_valid), 1);
        chk("pp_code",  32'(out_code),  32'h00);
        tick();
        chk("pp_pop", 32'(out_valid), 0);

        // Unrecognised pattern, then its repeat suppressed after glitches
        smp(7'h55, 4);
        chk("err_code", 32'(out_code), 32'h1F);
        chk("err_flag", 32'(out_err),  1);
        chk("err_pat",  32'(out_pattern[6:0]), 32'h55);
        tick();
        seen = 0;
        smp(7'h7F, 1); smp(7'h08, 2); smp(7'h55, 6);
        chk("err_suppressed", 32'(seen), 0);

        // Reset mid-operation with pending output and overrun set
        out_ready = 1'b0;
        smp(7'h21, 4);
        chk("r_pending", 32'(out_valid), 1);
        smp(7'h7F, 4);
        chk("r_overrun", 32'(overrun), 1);
        #5 resetn = 1'b0; #1;
        chk("r_valid0",   32'(out_valid), 0);
        chk("r_overrun0", 32'(overrun),   0);
        chk("r_code",     32'(out_code),  32'h11);
        @(negedge CLOCK_50); resetn = 1'b1; out_ready = 1'b1;
        smp(7'h21, 4);
        chk("r_reemit_valid", 32'(out_valid), 1);
        chk("r_reemit_code",  32'(out_code),  32'h0D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
